// File: rtl/alu.sv
// 16-bit registered ALU: result and optional {V,N,C,Z} flags appear one clock after operands.
// Build option: define ALU_FLAGS_EN to implement the flag logic; otherwise flags reads 4'b0000.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [2:0]  mode,
  output logic [15:0] out,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {
    M_ADD = 3'd0,
    M_SUB = 3'd1,
    M_AND = 3'd2,
    M_OR  = 3'd3,
    M_XOR = 3'd4,
    M_NOT = 3'd5,
    M_SHL = 3'd6,
    M_SHR = 3'd7
  } mode_e;

  mode_e       w_mode;
  logic [16:0] w_add;   // bit 16 = carry out
  logic [16:0] w_sub;   // bit 16 = borrow
  logic [16:0] w_shl;   // bit 16 = last bit shifted out the top
  logic [16:0] w_shr;   // bit 0  = last bit shifted out the bottom
  logic [15:0] w_res;
  logic [15:0] r_out;

  assign w_mode = mode_e'(mode);
  assign w_add  = {1'b0, in1} + {1'b0, in2};
  assign w_sub  = {1'b0, in1} - {1'b0, in2};
  assign w_shl  = {1'b0, in1} << in2[3:0];
  assign w_shr  = {in1, 1'b0} >> in2[3:0];

  always_comb begin
    w_res = 16'h0000;
    unique case (w_mode)
      M_ADD: w_res = w_add[15:0];
      M_SUB: w_res = w_sub[15:0];
      M_AND: w_res = in1 & in2;
      M_OR:  w_res = in1 | in2;
      M_XOR: w_res = in1 ^ in2;
      M_NOT: w_res = ~in1;
      M_SHL: w_res = w_shl[15:0];
      M_SHR: w_res = w_shr[16:1];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_out <= 16'h0000;
    else        r_out <= w_res;
  end

  assign out = r_out;

`ifdef ALU_FLAGS_EN
  logic       w_c;
  logic       w_v;
  logic [3:0] r_flags;

  always_comb begin
    w_c = 1'b0;
    w_v = 1'b0;
    unique case (w_mode)
      M_ADD: begin
        w_c = w_add[16];
        w_v = (in1[15] == in2[15]) && (w_add[15] != in1[15]);
      end
      M_SUB: begin
        w_c = w_sub[16];
        w_v = (in1[15] != in2[15]) && (w_sub[15] != in1[15]);
      end
      M_SHL: w_c = w_shl[16];
      M_SHR: w_c = w_shr[0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_flags <= 4'b0000;
    else        r_flags <= {w_v, w_res[15], w_c, (w_res == 16'h0000)};
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: table of hand-computed vectors plus reset/latency/hold sequences.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in1, in2;
  logic [2:0]  mode;
  logic [15:0] out;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .in1   (in1),
    .in2   (in2),
    .mode  (mode),
    .out   (out),
    .flags (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  m;
    logic [15:0] eo;
    logic [3:0]  ef;   // {V,N,C,Z} when flags are built in
  } vec_t;

  function automatic logic [3:0] exp_f(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] eo, input logic [3:0] ef);
    checks++;
    if (out !== eo || flags !== exp_f(ef)) begin
      failures++;
      $display("FAIL %s: out=%h flags=%b, expected out=%h flags=%b",
               name, out, flags, eo, exp_f(ef));
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m);
    in1 = a; in2 = b; mode = m;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_wrap",    16'hFFFF, 16'h0001, 3'd0, 16'h0000, 4'b0011});
    vecs.push_back('{"add_ovf",     16'h7FFF, 16'h0001, 3'd0, 16'h8000, 4'b1100});
    vecs.push_back('{"add_neg_ovf", 16'h8000, 16'h8000, 3'd0, 16'h0000, 4'b1011});
    vecs.push_back('{"sub_borrow",  16'h0003, 16'h0005, 3'd1, 16'hFFFE, 4'b0110});
    vecs.push_back('{"sub_zero",    16'h00AA, 16'h00AA, 3'd1, 16'h0000, 4'b0001});
    vecs.push_back('{"sub_ovf",     16'h8000, 16'h0001, 3'd1, 16'h7FFF, 4'b1000});
    vecs.push_back('{"and",         16'hF0F0, 16'hFF00, 3'd2, 16'hF000, 4'b0100});
    vecs.push_back('{"or",          16'hF0F0, 16'hFF00, 3'd3, 16'hFFF0, 4'b0100});
    vecs.push_back('{"xor",         16'hF0F0, 16'hFF00, 3'd4, 16'h0FF0, 4'b0000});
    vecs.push_back('{"not",         16'hF0F0, 16'hFF00, 3'd5, 16'h0F0F, 4'b0000});
    vecs.push_back('{"and_zero",    16'h0F0F, 16'hF0F0, 3'd2, 16'h0000, 4'b0001});
    vecs.push_back('{"shl1",        16'h8001, 16'h0011, 3'd6, 16'h0002, 4'b0010});
    vecs.push_back('{"shr1",        16'h8001, 16'h0011, 3'd7, 16'h4000, 4'b0010});
    vecs.push_back('{"shl0",        16'h8001, 16'h0010, 3'd6, 16'h8001, 4'b0100});
    vecs.push_back('{"shr0",        16'h8001, 16'h0000, 3'd7, 16'h8001, 4'b0100});
    vecs.push_back('{"shl15",       16'h0001, 16'h000F, 3'd6, 16'h8000, 4'b0100});
    vecs.push_back('{"shr15",       16'h8000, 16'h000F, 3'd7, 16'h0001, 4'b0000});
    vecs.push_back('{"shl2_cz",     16'h4000, 16'h0002, 3'd6, 16'h0000, 4'b0011});

    // Reset holds outputs at zero across edges, then first edge loads.
    reset = 1'b0;
    drive(16'h1234, 16'h1111, 3'd0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 16'h0000, 4'b0000);
    @(negedge clk) reset = 1'b1;
    #1 chk("release_no_edge", 16'h0000, 4'b0000);
    @(posedge clk); #1 chk("release_first", 16'h2345, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk) drive(vecs[i].a, vecs[i].b, vecs[i].m);
      @(posedge clk); #1 chk(vecs[i].name, vecs[i].eo, vecs[i].ef);
    end

    // Operand changes between edges must not reach out.
    @(negedge clk) drive(16'h0001, 16'h0001, 3'd0);
    @(posedge clk); #1 chk("lat_load", 16'h0002, 4'b0000);
    drive(16'h0100, 16'h0001, 3'd0);
    #2 chk("hold_between", 16'h0002, 4'b0000);
    @(negedge clk) drive(16'hFFFF, 16'h0001, 3'd0);
    #1 chk("hold_negedge", 16'h0002, 4'b0000);
    @(posedge clk); #1 chk("lat_next", 16'h0000, 4'b0011);

    // Mid-cycle reset clears without a clock edge and discards the pending result.
    drive(16'h7FFF, 16'h0001, 3'd0);
    #1 reset = 1'b0;
    #1 chk("async_reset", 16'h0000, 4'b0000);
    @(posedge clk); #1 chk("reset_over_edge", 16'h0000, 4'b0000);
    @(negedge clk) reset = 1'b1;
    #1 chk("no_partial", 16'h0000, 4'b0000);
    @(posedge clk); #1 chk("post_reset", 16'h8000, 4'b1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
